// File: rtl/register_wb_gen.sv
// ============================================================================
// Module      : register_wb_gen
// Description : Write-back stage between execute and the register file.
//               Decodes a 4-bit op into zero, one or two register writes;
//               with a single write port, dual writes take two cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_wb_gen #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int WR_PORTS = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] r1,
    input  logic [DW-1:0] r2,
    input  logic [AW-1:0] a1,
    input  logic [AW-1:0] a2,
    input  logic [3:0]    op,
    input  logic          proceed,
    output logic [DW-1:0] wr1,
    output logic [DW-1:0] wr2,
    output logic [AW-1:0] wa1,
    output logic [AW-1:0] wa2,
    output logic [1:0]    write,
    output logic          busy
);

    localparam bit        SERIAL   = (WR_PORTS == 1);
    localparam logic      S_IDLE   = 1'b0;
    localparam logic      S_SECOND = 1'b1;

    localparam logic [3:0] OP_R1_A1   = 4'd1;
    localparam logic [3:0] OP_R1_A2   = 4'd2;
    localparam logic [3:0] OP_R1_R2A  = 4'd3;
    localparam logic [3:0] OP_R2_A1   = 4'd4;
    localparam logic [3:0] OP_R2_A2   = 4'd5;
    localparam logic [3:0] OP_R2_R1A  = 4'd6;
    localparam logic [3:0] OP_DUAL_A  = 4'd7;
    localparam logic [3:0] OP_DUAL_B  = 4'd8;
    localparam logic [3:0] OP_DUAL_NX = 4'd9;

    logic          state_q, state_d;
    logic [DW-1:0] wr1_q, wr1_d;
    logic [DW-1:0] wr2_q, wr2_d;
    logic [AW-1:0] wa1_q, wa1_d;
    logic [AW-1:0] wa2_q, wa2_d;
    logic [1:0]    write_q, write_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] pend_data_q, pend_data_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;

    logic          dec_single;
    logic          dec_dual;
    logic          dec_collide;
    logic [DW-1:0] dec_d1, dec_d2;
    logic [AW-1:0] dec_a1, dec_a2;
    logic          accept;

    assign accept = proceed && (state_q == S_IDLE);

    // Op decode: first pair (d1,a1) and, for dual ops, second pair (d2,a2)
    always_comb begin
        dec_single = 1'b0;
        dec_dual   = 1'b0;
        dec_d1     = r1;
        dec_a1     = a1;
        dec_d2     = r2;
        dec_a2     = a2;
        case (op)
            OP_R1_A1: begin
                dec_single = 1'b1;
            end
            OP_R1_A2: begin
                dec_single = 1'b1;
                dec_a1     = a2;
            end
            OP_R1_R2A: begin
                dec_single = 1'b1;
                dec_a1     = r2[AW-1:0];
            end
            OP_R2_A1: begin
                dec_single = 1'b1;
                dec_d1     = r2;
            end
            OP_R2_A2: begin
                dec_single = 1'b1;
                dec_d1     = r2;
                dec_a1     = a2;
            end
            OP_R2_R1A: begin
                dec_single = 1'b1;
                dec_d1     = r2;
                dec_a1     = r1[AW-1:0];
            end
            OP_DUAL_A: begin
                dec_dual = 1'b1;
            end
            OP_DUAL_B: begin
                dec_dual = 1'b1;
                dec_a1   = a2;
                dec_a2   = a1;
            end
            OP_DUAL_NX: begin
                dec_dual = 1'b1;
                dec_a2   = a1 + AW'(1);
            end
            default: begin
                dec_single = 1'b0;
                dec_dual   = 1'b0;
            end
        endcase
    end

    // Equal addresses collapse to one write; the later data wins
    assign dec_collide = dec_dual && (dec_a1 == dec_a2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr1_q       <= '0;
            wr2_q       <= '0;
            wa1_q       <= '0;
            wa2_q       <= '0;
            write_q     <= '0;
            busy_q      <= 1'b0;
            pend_data_q <= '0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            wr1_q       <= wr1_d;
            wr2_q       <= wr2_d;
            wa1_q       <= wa1_d;
            wa2_q       <= wa2_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            pend_data_q <= pend_data_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && dec_dual && !dec_collide && SERIAL) begin
                    state_d = S_SECOND;
                end
            end
            S_SECOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr1_d       = wr1_q;
        wr2_d       = wr2_q;
        wa1_d       = wa1_q;
        wa2_d       = wa2_q;
        write_d     = 2'b00;
        busy_d      = 1'b0;
        pend_data_d = pend_data_q;
        pend_addr_d = pend_addr_q;
        if (state_q == S_SECOND) begin
            wr1_d   = pend_data_q;
            wa1_d   = pend_addr_q;
            write_d = 2'b01;
        end else if (accept) begin
            if (dec_single) begin
                wr1_d   = dec_d1;
                wa1_d   = dec_a1;
                write_d = 2'b01;
            end else if (dec_collide) begin
                wr1_d   = dec_d2;
                wa1_d   = dec_a2;
                write_d = 2'b01;
            end else if (dec_dual) begin
                wr1_d = dec_d1;
                wa1_d = dec_a1;
                if (SERIAL) begin
                    // Port 2 is never driven here, so it stays at its reset 0
                    write_d     = 2'b01;
                    busy_d      = 1'b1;
                    pend_data_d = dec_d2;
                    pend_addr_d = dec_a2;
                end else begin
                    wr2_d   = dec_d2;
                    wa2_d   = dec_a2;
                    write_d = 2'b11;
                end
            end
        end
    end

    assign wr1   = wr1_q;
    assign wr2   = wr2_q;
    assign wa1   = wa1_q;
    assign wa2   = wa2_q;
    assign write = write_q;
    assign busy  = busy_q;

endmodule

`default_nettype wire
